alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters, for example the main datapath and a branch/compare helper.
- Arbitrates round-robin and latches the winner's operands and opcode. Drives the ALU for one cycle, registers the result and ALU signals, and returns them to the winner over a valid/ready response handshake.
- Sits between the requesters and the ALU instance. The ALU itself is unchanged.

---
 rtl/alu_arbiter_if.sv | 27 ++
 rtl/alu_arbiter.sv | 101 ++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Valid/ready request and response bundle between one requester and the
// ALU arbiter. The requester drives the master side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int SIGW  = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OPW-1:0]   req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [SIGW-1:0]  rsp_sig;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_sig
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_sig
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation takes IDLE (accept) -> EXEC (ALU driven) -> RESP (held until consumed).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int SIGW  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_arbiter_if.slave     r0,
  alu_arbiter_if.slave     r1,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_outC,
  input  logic [SIGW-1:0]  alu_sig,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic             owner;
  logic             grant_any;
  logic             grant_idx;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [OPW-1:0]   op_q;
  logic [SIGW-1:0]  sig_q;

  // Pointer only breaks ties; a lone requester always wins.
  assign grant_any = r0.req_valid | r1.req_valid;
  assign grant_idx = (r0.req_valid && r1.req_valid) ? ptr : r1.req_valid;
  assign accept    = (state == IDLE) && grant_any;
  assign rsp_done  = (state == RESP) && (owner ? r1.rsp_ready : r0.rsp_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this purely combinational; a
  // path that left state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:                  state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r0.req_ready  = reset_n && (state == IDLE) && grant_any && !grant_idx;
    r1.req_ready  = reset_n && (state == IDLE) && grant_any &&  grant_idx;
    r0.rsp_valid  = (state == RESP) && !owner;
    r1.rsp_valid  = (state == RESP) &&  owner;
    r0.rsp_result = result_q;
    r1.rsp_result = result_q;
    r0.rsp_sig    = sig_q;
    r1.rsp_sig    = sig_q;
    busy          = (state != IDLE);
  end

  // NOTE: the datapath registers are reset too, because result, sig and the
  // ALU operand outputs must read 0 after reset rather than X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      sig_q    <= '0;
    end else begin
      if (accept) begin
        ptr   <= ~grant_idx;
        owner <= grant_idx;
        a_q   <= grant_idx ? r1.req_a  : r0.req_a;
        b_q   <= grant_idx ? r1.req_b  : r0.req_b;
        op_q  <= grant_idx ? r1.req_op : r0.req_op;
      end
      if (state == EXEC) begin
        result_q <= alu_outC;
        sig_q    <= alu_sig;
      end
    end
  end

  // Driven straight from the operand latches so the ALU inputs never glitch.
  assign alu_srcA = a_q;
  assign alu_srcB = b_q;
  assign alu_op   = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU attached to the
// ALU-side ports.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;
  localparam int SIGW  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW), .SIGW(SIGW)) r0_if ();
  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW), .SIGW(SIGW)) r1_if ();

  logic [WIDTH-1:0] alu_srcA, alu_srcB, alu_outC;
  logic [OPW-1:0]   alu_op;
  logic [SIGW-1:0]  alu_sig;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .SIGW(SIGW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .r0       (r0_if),
    .r1       (r1_if),
    .alu_srcA (alu_srcA),
    .alu_srcB (alu_srcB),
    .alu_op   (alu_op),
    .alu_outC (alu_outC),
    .alu_sig  (alu_sig),
    .busy     (busy)
  );

  // Reference ALU: 000 add, 001 sub, 010 or, 011 lui, 100 and, 101 xor, 110 slt, 111 -> 0.
  always_comb begin
    case (alu_op)
      3'b000:  alu_outC = alu_srcA + alu_srcB;
      3'b001:  alu_outC = alu_srcA - alu_srcB;
      3'b010:  alu_outC = alu_srcA | alu_srcB;
      3'b011:  alu_outC = {alu_srcB[15:0], 16'h0000};
      3'b100:  alu_outC = alu_srcA & alu_srcB;
      3'b101:  alu_outC = alu_srcA ^ alu_srcB;
      3'b110:  alu_outC = {31'd0, $signed(alu_srcA) < $signed(alu_srcB)};
      default: alu_outC = '0;
    endcase
    alu_sig = {3'b000, alu_srcA == alu_srcB};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_if.req_valid = 1'b0; r0_if.req_a = '0; r0_if.req_b = '0; r0_if.req_op = '0; r0_if.rsp_ready = 1'b0;
    r1_if.req_valid = 1'b0; r1_if.req_a = '0; r1_if.req_b = '0; r1_if.req_op = '0; r1_if.rsp_ready = 1'b0;
  endtask

  task automatic drive_req(input bit idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [OPW-1:0] op, input logic v);
    if (idx) begin
      r1_if.req_valid = v; r1_if.req_a = a; r1_if.req_b = b; r1_if.req_op = op;
    end else begin
      r0_if.req_valid = v; r0_if.req_a = a; r0_if.req_b = b; r0_if.req_op = op;
    end
  endtask

  // One complete operation from a single requester, starting in IDLE at posedge+1.
  task automatic run_op(input bit idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [OPW-1:0] op, input logic [WIDTH-1:0] exp_res,
                        input logic [SIGW-1:0] exp_sig, input string tag);
    logic own_rdy, oth_rdy, own_vld, oth_vld;
    logic [WIDTH-1:0] res;
    logic [SIGW-1:0] sig;
    drive_req(idx, a, b, op, 1'b1);
    #1;
    own_rdy = idx ? r1_if.req_ready : r0_if.req_ready;
    oth_rdy = idx ? r0_if.req_ready : r1_if.req_ready;
    n_checks++; if (own_rdy !== 1'b1) begin n_fail++; $display("FAIL %s req_ready: got %b want 1", tag, own_rdy); end
    n_checks++; if (oth_rdy !== 1'b0) begin n_fail++; $display("FAIL %s other req_ready: got %b want 0", tag, oth_rdy); end
    tick();
    drive_req(idx, '0, '0, '0, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s exec busy: got %b want 1", tag, busy); end
    n_checks++; if (alu_op !== op) begin n_fail++; $display("FAIL %s alu_op: got %0h want %0h", tag, alu_op, op); end
    n_checks++; if (alu_srcA !== a || alu_srcB !== b) begin n_fail++; $display("FAIL %s alu_src: got %0h/%0h want %0h/%0h", tag, alu_srcA, alu_srcB, a, b); end
    tick();
    own_vld = idx ? r1_if.rsp_valid : r0_if.rsp_valid;
    oth_vld = idx ? r0_if.rsp_valid : r1_if.rsp_valid;
    res = idx ? r1_if.rsp_result : r0_if.rsp_result;
    sig = idx ? r1_if.rsp_sig : r0_if.rsp_sig;
    n_checks++; if (own_vld !== 1'b1) begin n_fail++; $display("FAIL %s rsp_valid: got %b want 1", tag, own_vld); end
    n_checks++; if (oth_vld !== 1'b0) begin n_fail++; $display("FAIL %s other rsp_valid: got %b want 0", tag, oth_vld); end
    n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL %s result: got %0h want %0h", tag, res, exp_res); end
    n_checks++; if (sig !== exp_sig) begin n_fail++; $display("FAIL %s sig: got %0h want %0h", tag, sig, exp_sig); end
    if (idx) r1_if.rsp_ready = 1'b1; else r0_if.rsp_ready = 1'b1;
    tick();
    own_vld = idx ? r1_if.rsp_valid : r0_if.rsp_valid;
    n_checks++; if (own_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s back to idle: got valid=%b busy=%b want 0/0", tag, own_vld, busy); end
    r0_if.rsp_ready = 1'b0;
    r1_if.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    r0_if.req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_checks++; if (r0_if.req_ready !== 1'b0 || r1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset req_ready: got %b/%b want 0/0", r0_if.req_ready, r1_if.req_ready); end
    n_checks++; if (r0_if.rsp_valid !== 1'b0 || r1_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b/%b want 0/0", r0_if.rsp_valid, r1_if.rsp_valid); end
    n_checks++; if (alu_srcA !== '0 || alu_srcB !== '0 || alu_op !== '0) begin n_fail++; $display("FAIL reset alu: got %0h/%0h/%0h want 0/0/0", alu_srcA, alu_srcB, alu_op); end
    n_checks++; if (r0_if.rsp_result !== '0 || r0_if.rsp_sig !== '0) begin n_fail++; $display("FAIL reset rsp data: got %0h/%0h want 0/0", r0_if.rsp_result, r0_if.rsp_sig); end
    r0_if.req_valid = 1'b0;
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    run_op(1'b0, 32'd5, 32'd3, 3'b000, 32'd8, 4'b0000, "add");
  endtask

  task automatic test_r1_ops();
    run_op(1'b1, 32'd7, 32'd7, 3'b001, 32'd0, 4'b0001, "sub_eq");
    run_op(1'b1, 32'd0, 32'h1234, 3'b011, 32'h1234_0000, 4'b0000, "lui");
    run_op(1'b1, 32'd9, 32'd4, 3'b111, 32'd0, 4'b0000, "illegal");
  endtask

  task automatic test_contention();
    logic [WIDTH-1:0] exp_res;
    logic [SIGW-1:0]  exp_sig;
    drive_req(1'b0, 32'd1, 32'd1, 3'b000, 1'b1);
    drive_req(1'b1, 32'hF0, 32'h0F, 3'b010, 1'b1);
    r0_if.rsp_ready = 1'b1;
    r1_if.rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      bit own = k[0];
      exp_res = own ? 32'hFF : 32'd2;
      exp_sig = own ? 4'b0000 : 4'b0001;
      n_checks++; if (r0_if.req_ready !== !own || r1_if.req_ready !== own) begin n_fail++; $display("FAIL contention grant %0d: got %b/%b want r%0d", k, r0_if.req_ready, r1_if.req_ready, own); end
      tick();
      n_checks++; if (r0_if.req_ready !== 1'b0 || r1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL contention exec ready %0d: got %b/%b want 0/0", k, r0_if.req_ready, r1_if.req_ready); end
      tick();
      n_checks++; if (r0_if.rsp_valid !== !own || r1_if.rsp_valid !== own) begin n_fail++; $display("FAIL contention rsp owner %0d: got %b/%b want r%0d", k, r0_if.rsp_valid, r1_if.rsp_valid, own); end
      n_checks++; if (r0_if.rsp_result !== exp_res || r0_if.rsp_sig !== exp_sig) begin n_fail++; $display("FAIL contention result %0d: got %0h/%0h want %0h/%0h", k, r0_if.rsp_result, r0_if.rsp_sig, exp_res, exp_sig); end
      tick();
      if (k == 5) idle_inputs();
    end
  endtask

  task automatic test_backpressure();
    drive_req(1'b0, 32'd10, 32'd20, 3'b000, 1'b1);
    tick();
    drive_req(1'b0, '0, '0, '0, 1'b0);
    drive_req(1'b1, 32'd2, 32'd2, 3'b000, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (r0_if.rsp_valid !== 1'b1 || r0_if.rsp_result !== 32'd30 || r0_if.rsp_sig !== 4'b0000) begin n_fail++; $display("FAIL stall hold %0d: got v=%b r=%0h s=%0h want 1/1e/0", k, r0_if.rsp_valid, r0_if.rsp_result, r0_if.rsp_sig); end
      n_checks++; if (busy !== 1'b1 || r0_if.req_ready !== 1'b0 || r1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL stall busy/ready %0d: got %b/%b/%b want 1/0/0", k, busy, r0_if.req_ready, r1_if.req_ready); end
      tick();
    end
    r0_if.rsp_ready = 1'b1;
    drive_req(1'b1, '0, '0, '0, 1'b0);
    tick();
    n_checks++; if (r0_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall release: got v=%b busy=%b want 0/0", r0_if.rsp_valid, busy); end
    r0_if.rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_req(1'b1, 32'd3, 32'd4, 3'b000, 1'b1);
    tick();
    drive_req(1'b1, '0, '0, '0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || alu_srcA !== '0 || alu_srcB !== '0 || alu_op !== '0) begin n_fail++; $display("FAIL async reset outputs: got busy=%b a=%0h b=%0h op=%0h want 0", busy, alu_srcA, alu_srcB, alu_op); end
    n_checks++; if (r1_if.rsp_valid !== 1'b0 || r1_if.rsp_result !== '0) begin n_fail++; $display("FAIL async reset rsp: got v=%b r=%0h want 0/0", r1_if.rsp_valid, r1_if.rsp_result); end
    @(posedge clk);
    #3 reset_n = 1'b1;
    r0_if.rsp_ready = 1'b1;
    r1_if.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (r0_if.rsp_valid !== 1'b0 || r1_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post reset stale %0d: got %b/%b busy=%b want 0", k, r0_if.rsp_valid, r1_if.rsp_valid, busy); end
    end
    r0_if.rsp_ready = 1'b0;
    r1_if.rsp_ready = 1'b0;
    drive_req(1'b0, 32'd6, 32'd6, 3'b001, 1'b1);
    drive_req(1'b1, 32'd1, 32'd2, 3'b000, 1'b1);
    #1;
    n_checks++; if (r0_if.req_ready !== 1'b1 || r1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL post reset pointer: got %b/%b want 1/0", r0_if.req_ready, r1_if.req_ready); end
    tick();
    idle_inputs();
    tick();
    n_checks++; if (r0_if.rsp_valid !== 1'b1 || r0_if.rsp_result !== 32'd0 || r0_if.rsp_sig !== 4'b0001) begin n_fail++; $display("FAIL post reset op: got v=%b r=%0h s=%0h want 1/0/1", r0_if.rsp_valid, r0_if.rsp_result, r0_if.rsp_sig); end
    r0_if.rsp_ready = 1'b1;
    tick();
    r0_if.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    drive_req(1'b0, 32'd100, 32'd1, 3'b001, 1'b1);
    tick();
    t0 = cyc;
    drive_req(1'b0, '0, '0, '0, 1'b0);
    tick();
    r0_if.rsp_ready = 1'b1;
    drive_req(1'b0, 32'd2, 32'd3, 3'b000, 1'b1);
    #1;
    n_checks++; if (r0_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b ready during rsp: got %b want 0", r0_if.req_ready); end
    n_checks++; if (r0_if.rsp_valid !== 1'b1 || r0_if.rsp_result !== 32'd99) begin n_fail++; $display("FAIL b2b first rsp: got v=%b r=%0h want 1/63", r0_if.rsp_valid, r0_if.rsp_result); end
    tick();
    r0_if.rsp_ready = 1'b0;
    n_checks++; if (r0_if.rsp_valid !== 1'b0 || r0_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b idle: got rsp_v=%b req_rdy=%b want 0/1", r0_if.rsp_valid, r0_if.req_ready); end
    tick();
    t1 = cyc;
    drive_req(1'b0, '0, '0, '0, 1'b0);
    n_checks++; if (t1 - t0 !== 3) begin n_fail++; $display("FAIL b2b cadence: got %0d cycles want 3", t1 - t0); end
    tick();
    n_checks++; if (r0_if.rsp_valid !== 1'b1 || r0_if.rsp_result !== 32'd5) begin n_fail++; $display("FAIL b2b second rsp: got v=%b r=%0h want 1/5", r0_if.rsp_valid, r0_if.rsp_result); end
    r0_if.rsp_ready = 1'b1;
    tick();
    r0_if.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_r1_ops();
    test_contention();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
